// File: rtl/uio_bus_arbiter.sv
// Round-robin owner arbitration for the shared 8-bit uio pin bank.
// Pins are tri-stated for TURN_CYC cycles before and after each ownership.
module uio_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 16,
  parameter int TURN_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   dir,
  input  logic [8*N_REQ-1:0] wdata,
  input  logic [7:0]         uio_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [7:0]         uio_out,
  output logic [7:0]         uio_oe,
  output logic [7:0]         rdata,
  output logic               rvalid,
  output logic               busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {IDLE, TURN_IN, OWN, TURN_OUT} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   owner, owner_d;
  logic            owner_dir, owner_dir_d;
  logic [PW-1:0]   rr_ptr, rr_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic [TW-1:0]   turn_cnt, turn_d;
  logic            found;
  logic [PW-1:0]   winner;
  logic [PW:0]     scan;
  logic [PW-1:0]   owner_next;
  logic            release_now;

  assign owner_next  = (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign release_now = !req[owner] || !ena;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case/if tree can infer a latch.
    state_d     = state;
    owner_d     = owner;
    owner_dir_d = owner_dir;
    rr_d        = rr_ptr;
    hold_d      = hold_cnt;
    turn_d      = turn_cnt;
    found       = 1'b0;
    winner      = '0;
    scan        = '0;

    // First set request at or cyclically above rr_ptr.
    for (int i = 0; i < N_REQ; i++) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(i);
      if (scan >= (PW+1)'(N_REQ)) scan = scan - (PW+1)'(N_REQ);
      if (!found && req[scan[PW-1:0]]) begin
        found  = 1'b1;
        winner = scan[PW-1:0];
      end
    end

    case (state)
      IDLE: begin
        if (ena && found) begin
          state_d     = TURN_IN;
          owner_d     = winner;
          owner_dir_d = dir[winner];
          turn_d      = TW'(1);
        end
      end
      TURN_IN: begin
        if (release_now) begin
          state_d = TURN_OUT;
          turn_d  = TW'(1);
          rr_d    = owner_next;
        end else if (turn_cnt == TW'(TURN_CYC)) begin
          state_d = OWN;
          hold_d  = HW'(1);
        end else begin
          turn_d = turn_cnt + 1'b1;
        end
      end
      OWN: begin
        if (release_now || hold_cnt == HW'(MAX_HOLD)) begin
          state_d = TURN_OUT;
          turn_d  = TW'(1);
          rr_d    = owner_next;
        end else begin
          hold_d = hold_cnt + 1'b1;
        end
      end
      TURN_OUT: begin
        if (turn_cnt == TW'(TURN_CYC)) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          turn_d = turn_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      owner_dir <= 1'b0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      turn_cnt  <= '0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      owner_dir <= owner_dir_d;
      rr_ptr    <= rr_d;
      hold_cnt  <= hold_d;
      turn_cnt  <= turn_d;
    end
  end

  // Outputs follow the current state one edge later, so pins switch only
  // after the owner has settled and release together with gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      uio_out <= 8'h00;
      uio_oe  <= 8'h00;
      rdata   <= 8'h00;
      rvalid  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      gnt     <= (state == OWN) ? (N_REQ'(1) << owner) : '0;
      uio_oe  <= (state == OWN && owner_dir) ? 8'hFF : 8'h00;
      uio_out <= (state == OWN && owner_dir) ? wdata[{owner, 3'b000} +: 8] : 8'h00;
      rvalid  <= (state == OWN) && !owner_dir;
      if (state == OWN && !owner_dir) rdata <= uio_in;
      busy    <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: per-cycle vector table plus hand-written
// sequences for asynchronous reset and full round-robin rotation.
module tb_uio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req;
  logic [3:0]  dir;
  logic [31:0] wdata;
  logic [7:0]  uio_in;
  logic [3:0]  gnt;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        busy;

  int errors = 0;
  int checks = 0;

  uio_bus_arbiter #(.N_REQ(4), .MAX_HOLD(16), .TURN_CYC(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .req    (req),
    .dir    (dir),
    .wdata  (wdata),
    .uio_in (uio_in),
    .gnt    (gnt),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .rdata  (rdata),
    .rvalid (rvalid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] dir;
    logic       ena;
    logic [7:0] uin;
    logic [3:0] gnt;
    logic [7:0] oe;
    logic [7:0] out;
    logic       rv;
    logic [7:0] rd;
    logic       busy;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int len;
    int bad;
    logic [3:0] exp_g;
    logic [7:0] exp_d;

    // req, dir, ena, uio_in | gnt, oe, out, rvalid, rdata, busy
    // Single writer 0 for 5 request cycles.
    tv.push_back('{4'b0001, 4'b0001, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    tv.push_back('{4'b0001, 4'b0001, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b0001, 4'b0001, 1'b1, 8'h00, 4'b0001, 8'hFF, 8'hA5, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b0001, 4'b0001, 1'b1, 8'h00, 4'b0001, 8'hFF, 8'hA5, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b0001, 4'b0001, 1'b1, 8'h00, 4'b0001, 8'hFF, 8'hA5, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b0000, 4'b0001, 1'b1, 8'h00, 4'b0001, 8'hFF, 8'hA5, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b0000, 4'b0001, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b0000, 4'b0001, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    // Reader 2; dir toggled mid-ownership must be ignored.
    tv.push_back('{4'b0100, 4'b0000, 1'b1, 8'h3C, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    tv.push_back('{4'b0100, 4'b0000, 1'b1, 8'h3C, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b0100, 4'b0000, 1'b1, 8'h3C, 4'b0100, 8'h00, 8'h00, 1'b1, 8'h3C, 1'b1});
    tv.push_back('{4'b0100, 4'b0100, 1'b1, 8'h5A, 4'b0100, 8'h00, 8'h00, 1'b1, 8'h5A, 1'b1});
    tv.push_back('{4'b0100, 4'b0000, 1'b1, 8'hC3, 4'b0100, 8'h00, 8'h00, 1'b1, 8'hC3, 1'b1});
    tv.push_back('{4'b0000, 4'b0000, 1'b1, 8'hC3, 4'b0100, 8'h00, 8'h00, 1'b1, 8'hC3, 1'b1});
    tv.push_back('{4'b0000, 4'b0000, 1'b1, 8'hC3, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    // One-cycle pulse on req[1]: no grant, rr_ptr moves to 2 (so 1011 picks 3).
    tv.push_back('{4'b0010, 4'b0000, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    tv.push_back('{4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b0000, 4'b0000, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    tv.push_back('{4'b1011, 4'b1111, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    tv.push_back('{4'b1011, 4'b1111, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b1011, 4'b1111, 1'b1, 8'h00, 4'b1000, 8'hFF, 8'h44, 1'b0, 8'h00, 1'b1});
    // ena drops during owner 3; no grant while low; resumes at requester 0.
    tv.push_back('{4'b1111, 4'b1111, 1'b0, 8'h00, 4'b1000, 8'hFF, 8'h44, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b1111, 4'b1111, 1'b0, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b1111, 4'b1111, 1'b0, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    tv.push_back('{4'b1111, 4'b1111, 1'b0, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    tv.push_back('{4'b1111, 4'b1111, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    tv.push_back('{4'b1111, 4'b1111, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b1111, 4'b1111, 1'b1, 8'h00, 4'b0001, 8'hFF, 8'hA5, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b0000, 4'b1111, 1'b1, 8'h00, 4'b0001, 8'hFF, 8'hA5, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b0000, 4'b1111, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1});
    tv.push_back('{4'b0000, 4'b1111, 1'b1, 8'h00, 4'b0000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});

    rst_n  = 1'b0;
    ena    = 1'b1;
    req    = 4'b0000;
    dir    = 4'b0000;
    wdata  = 32'h4433_22A5;
    uio_in = 8'h00;
    tick();
    tick();
    check("reset_gnt",    32'(gnt),     32'h0);
    check("reset_oe",     32'(uio_oe),  32'h0);
    check("reset_out",    32'(uio_out), 32'h0);
    check("reset_rdata",  32'(rdata),   32'h0);
    check("reset_rvalid", 32'(rvalid),  32'h0);
    check("reset_busy",   32'(busy),    32'h0);
    #2 rst_n = 1'b1;
    tick();

    for (int k = 0; k < tv.size(); k++) begin
      req    = tv[k].req;
      dir    = tv[k].dir;
      ena    = tv[k].ena;
      uio_in = tv[k].uin;
      tick();
      check($sformatf("vec%0d_gnt", k),    32'(gnt),     32'(tv[k].gnt));
      check($sformatf("vec%0d_oe", k),     32'(uio_oe),  32'(tv[k].oe));
      check($sformatf("vec%0d_out", k),    32'(uio_out), 32'(tv[k].out));
      check($sformatf("vec%0d_rvalid", k), 32'(rvalid),  32'(tv[k].rv));
      check($sformatf("vec%0d_busy", k),   32'(busy),    32'(tv[k].busy));
      if (tv[k].rv) check($sformatf("vec%0d_rdata", k), 32'(rdata), 32'(tv[k].rd));
    end

    // Asynchronous reset while requester 1 is driving (rr_ptr is 1 here).
    req = 4'b0010;
    dir = 4'b0010;
    n = 0;
    while (gnt != 4'b0010 && n < 20) begin
      tick();
      n++;
    end
    check("arst_grant_seen", 32'(gnt),    32'h2);
    check("arst_pre_oe",     32'(uio_oe), 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    check("arst_gnt",  32'(gnt),     32'h0);
    check("arst_oe",   32'(uio_oe),  32'h0);
    check("arst_out",  32'(uio_out), 32'h0);
    check("arst_busy", 32'(busy),    32'h0);
    req = 4'b1111;
    dir = 4'b1111;
    #2 rst_n = 1'b1;

    // Full rotation from rr_ptr=0 with everyone requesting: 0,1,2,3,0.
    for (int g = 0; g < 5; g++) begin
      n   = 0;
      bad = 0;
      while (gnt == 4'b0000 && n < 40) begin
        if (uio_oe != 8'h00) bad++;
        tick();
        n++;
      end
      check($sformatf("rot%0d_gap_oe", g), 32'(bad), 32'h0);
      if (n >= 40) begin
        check($sformatf("rot%0d_timeout", g), 32'(n), 32'd0);
        break;
      end
      if (g > 0) check($sformatf("rot%0d_gap_ge2", g), 32'(n >= 2), 32'h1);
      exp_g = 4'b0001 << (g % 4);
      exp_d = wdata[8*(g%4) +: 8];
      check($sformatf("rot%0d_owner", g), 32'(gnt), 32'(exp_g));
      len = 0;
      bad = 0;
      while (gnt == exp_g && len < 40) begin
        if (uio_oe != 8'hFF || uio_out != exp_d) bad++;
        tick();
        len++;
      end
      check($sformatf("rot%0d_pins", g), 32'(bad), 32'h0);
      check($sformatf("rot%0d_len", g),  32'(len), 32'd16);
      check($sformatf("rot%0d_release", g), 32'(gnt), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
